// File: rtl/ex_unit.sv
// RV32I integer execute stage: decodes R/I-type ALU ops and registers the result with its rd tag.
// Define EX_MULDIV_EN to add the iterative shift-add MUL path (R-type funct7=0000001, funct3=000).
module ex_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_illegal,
  output logic             busy
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MULDV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef EX_MULDIV_EN
    , S_MUL = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic              illegal_q, illegal_d;

  logic              is_r, is_i, f7_base, f7_alt;
  logic              dec_illegal, dec_mul;
  logic [XLEN-1:0]   alu_res;
  logic [SHW-1:0]    shamt;
  logic              accept;

`ifdef EX_MULDIV_EN
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  assign in_ready    = !busy_q && (!valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign out_result  = result_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

  // Decode and single-cycle ALU; illegal/multi-cycle ops produce zero here.
  always_comb begin
    alu_res     = '0;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    is_r        = (in_opcode == OP_R);
    is_i        = (in_opcode == OP_I);
    f7_base     = (in_funct7 == F7_BASE);
    f7_alt      = (in_funct7 == F7_ALT);
    shamt       = in_b[SHW-1:0];

    if (is_r) begin
      if (f7_base) begin
        dec_illegal = 1'b0;
      end else if (f7_alt && (in_funct3 == 3'b000 || in_funct3 == 3'b101)) begin
        dec_illegal = 1'b0;
`ifdef EX_MULDIV_EN
      end else if (in_funct7 == F7_MULDV && in_funct3 == 3'b000) begin
        dec_mul = 1'b1;
`endif
      end else begin
        dec_illegal = 1'b1;
      end
    end else if (is_i) begin
      if (in_funct3 == 3'b001 && !f7_base) dec_illegal = 1'b1;
      if (in_funct3 == 3'b101 && !f7_base && !f7_alt) dec_illegal = 1'b1;
    end else begin
      dec_illegal = 1'b1;
    end

    case (in_funct3)
      3'b000:  alu_res = (is_r && f7_alt) ? in_a - in_b : in_a + in_b;
      3'b001:  alu_res = in_a << shamt;
      3'b010:  alu_res = XLEN'($signed(in_a) < $signed(in_b));
      3'b011:  alu_res = XLEN'(in_a < in_b);
      3'b100:  alu_res = in_a ^ in_b;
      3'b101:  alu_res = f7_alt ? $unsigned($signed(in_a) >>> shamt) : in_a >> shamt;
      3'b110:  alu_res = in_a | in_b;
      default: alu_res = in_a & in_b;
    endcase

    if (dec_illegal || dec_mul) alu_res = '0;
  end

  // Next-state: accept/retire in IDLE/HOLD, iterate in MUL; flush overrides.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    result_d  = result_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
`ifdef EX_MULDIV_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`endif

    case (state_q)
`ifdef EX_MULDIV_EN
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(XLEN)) begin
          state_d   = S_HOLD;
          busy_d    = 1'b0;
          valid_d   = 1'b1;
          result_d  = acc_d;
          illegal_d = 1'b0;
        end
      end
`endif
      default: begin
        if (valid_q && out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
        if (accept) begin
          rd_d = in_rd;
`ifdef EX_MULDIV_EN
          if (dec_mul) begin
            state_d  = S_MUL;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            acc_d    = '0;
            mcand_d  = in_a;
            mplier_d = in_b;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d   = S_HOLD;
            valid_d   = 1'b1;
            result_d  = alu_res;
            illegal_d = dec_illegal;
          end
        end
      end
    endcase

    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef EX_MULDIV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: vector table for the ALU/decode plus hand sequences for
// backpressure, flush, reset and the MUL path (EX_MULDIV_EN).
module tb_ex_unit;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal, busy;

  int total = 0;
  int bad   = 0;

  ex_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] rd, logic [31:0] res, logic ill);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.res = res; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_opcode = v.op;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rd     = v.rd;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, out_result, v.res);
    chk({tag, ".rd"}, 32'(out_rd), 32'(v.rd));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(v.ill));
  endtask

  vec_t va, vb, vc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;

    vecs.push_back(mk(32'h7FFFFFFF, 32'h1,        R, 3'b000, 7'h00, 5'd3,  32'h80000000, 1'b0));
    vecs.push_back(mk(32'h0,        32'h1,        R, 3'b000, 7'h20, 5'd4,  32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h24,       R, 3'b101, 7'h20, 5'd5,  32'hF8000000, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h24,       R, 3'b101, 7'h00, 5'd6,  32'h08000000, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h1,        R, 3'b010, 7'h00, 5'd7,  32'h1,        1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'h1,        R, 3'b011, 7'h00, 5'd8,  32'h0,        1'b0));
    vecs.push_back(mk(32'h5,        32'hFFFFFFFE, R, 3'b010, 7'h00, 5'd9,  32'h0,        1'b0));
    vecs.push_back(mk(32'h5,        32'hFFFFFFFE, R, 3'b011, 7'h00, 5'd10, 32'h1,        1'b0));
    vecs.push_back(mk(32'h80000000, 32'h1,        R, 3'b000, 7'h20, 5'd11, 32'h7FFFFFFF, 1'b0));
    vecs.push_back(mk(32'h1,        32'h1F,       I, 3'b001, 7'h00, 5'd12, 32'h80000000, 1'b0));
    vecs.push_back(mk(32'hF0F0F0F0, 32'hFFFFFFFF, I, 3'b100, 7'h7F, 5'd13, 32'h0F0F0F0F, 1'b0));
    vecs.push_back(mk(32'h00FF00FF, 32'h00000F00, I, 3'b110, 7'h00, 5'd14, 32'h00FF0FFF, 1'b0));
    vecs.push_back(mk(32'h12345678, 32'h000000FF, I, 3'b111, 7'h00, 5'd15, 32'h00000078, 1'b0));
    vecs.push_back(mk(32'd100,      32'h00000400, I, 3'b000, 7'h20, 5'd16, 32'h00000464, 1'b0));
    vecs.push_back(mk(32'hFFFFFF00, 32'h00000408, I, 3'b101, 7'h20, 5'd17, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h0,        I, 3'b010, 7'h00, 5'd18, 32'h1,        1'b0));
    vecs.push_back(mk(32'h1,        32'h2,        7'b0000011, 3'b000, 7'h00, 5'd19, 32'h0, 1'b1));
    vecs.push_back(mk(32'hFF,       32'h0F,       R, 3'b100, 7'h20, 5'd20, 32'h0,        1'b1));
    vecs.push_back(mk(32'h1,        32'h0000041F, I, 3'b001, 7'h20, 5'd21, 32'h0,        1'b1));
    vecs.push_back(mk(32'h3,        32'h5,        R, 3'b001, 7'h01, 5'd22, 32'h0,        1'b1));
    vecs.push_back(mk(32'h3,        32'h5,        R, 3'b110, 7'h40, 5'd23, 32'h0,        1'b1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_result", out_result, 32'd0);
    chk("rst.out_rd", 32'(out_rd), 32'd0);
    chk("rst.out_illegal", 32'(out_illegal), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table: each negedge checks the previous op and offers the next.
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) begin
        check_out($sformatf("vec%0d", i - 1), vecs[i-1]);
      end
      if (i < vecs.size()) begin
        chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        apply(vecs[i]);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held stable, nothing accepted, then back-to-back release.
    va = mk(32'd1, 32'd2, R, 3'b000, 7'h00, 5'd1, 32'd3, 1'b0);
    vb = mk(32'd5, 32'd3, R, 3'b100, 7'h00, 5'd2, 32'd6, 1'b0);
    vc = mk(32'hF0, 32'h3C, R, 3'b111, 7'h00, 5'd3, 32'h30, 1'b0);
    apply(va);
    @(negedge clk);
    check_out("bp.a", va);
    out_ready = 1'b0;
    apply(vb);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      check_out("bp.hold", va);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.b", vb);
    apply(vc);
    @(negedge clk);
    check_out("bp.c", vc);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.nodup", 32'(out_valid), 32'd0);

    // Flush a held result while a new op is accepted in the same cycle.
    out_ready = 1'b0;
    apply(va);
    @(negedge clk);
    chk("fl.pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    apply(vb);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.busy", 32'(busy), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("fl.discarded", 32'(out_valid), 32'd0);

    // Reset while a result is held.
    out_ready = 1'b0;
    apply(vecs[17]);
    @(negedge clk);
    chk("rh.pre_illegal", 32'(out_illegal), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rh.out_valid", 32'(out_valid), 32'd0);
    chk("rh.out_rd", 32'(out_rd), 32'd0);
    chk("rh.out_illegal", 32'(out_illegal), 32'd0);
    chk("rh.busy", 32'(busy), 32'd0);
    apply(vecs[0]);
    @(negedge clk);
    check_out("rh.add", vecs[0]);
    in_valid = 1'b0;
    @(negedge clk);

`ifdef EX_MULDIV_EN
    // MUL: busy for 32 cycles, result after the 32nd edge following accept.
    vb = mk(32'h0000FFFF, 32'h00010001, R, 3'b000, 7'h01, 5'd9, 32'hFFFFFFFF, 1'b0);
    apply(vb);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("mul.busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("mul.in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("mul.valid%0d", k), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("mul.busy_done", 32'(busy), 32'd0);
    check_out("mul", vb);
    @(negedge clk);

    // Flush part-way through a MUL.
    apply(vb);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mfl.out_valid", 32'(out_valid), 32'd0);
    chk("mfl.busy", 32'(busy), 32'd0);
    apply(va);
    @(negedge clk);
    check_out("mfl.add", va);
    in_valid = 1'b0;

    // Reset part-way through a MUL.
    @(negedge clk);
    apply(vb);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.out_rd", 32'(out_rd), 32'd0);
    apply(va);
    @(negedge clk);
    check_out("mrst.add", va);
    in_valid = 1'b0;
`else
    // MUL encoding without the multiplier is a single-cycle illegal op.
    vb = mk(32'h0000FFFF, 32'h00010001, R, 3'b000, 7'h01, 5'd9, 32'h0, 1'b1);
    apply(vb);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul.busy", 32'(busy), 32'd0);
    check_out("mul.illegal", vb);
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
